lsq_alloc_ctrl: RTL



---
 rtl/lsq_alloc_ctrl_pkg.sv | 41 ++++
 rtl/lsq_ptr_ctrl.sv | 61 ++++++
 rtl/lsq_alloc_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/lsq_alloc_ctrl_pkg.sv
// Shared core types and circular-pointer helpers for LQ/SQ (also used by ROB/FTQ).
// Pointers are {flipped, idx}; sizes are powers of two so the flipped bit is the carry out of idx.
`ifndef LQSIZE
`define LQSIZE 64
`endif
`ifndef SQSIZE
`define SQSIZE 64
`endif

package lsq_alloc_ctrl_pkg;

    localparam int LQSIZE = `LQSIZE;
    localparam int SQSIZE = `SQSIZE;

    typedef struct packed {
        logic                      flipped;
        logic [$clog2(LQSIZE)-1:0] value;
    } lqIdx_t;

    typedef struct packed {
        logic                      flipped;
        logic [$clog2(SQSIZE)-1:0] value;
    } sqIdx_t;

    localparam int PTR_MAX_W = 16;
    typedef logic [PTR_MAX_W-1:0] ptr_t;

    function automatic ptr_t ptr_add(input ptr_t ptr, input ptr_t n, input int unsigned size);
        ptr_t mask;
        mask = ptr_t'(2 * size - 1);
        return (ptr + n) & mask;
    endfunction

    // Distance a - b; differing flipped bits add SIZE through the modulo-2*SIZE wrap.
    function automatic ptr_t ptr_dist(input ptr_t a, input ptr_t b, input int unsigned size);
        ptr_t mask;
        mask = ptr_t'(2 * size - 1);
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/lsq_ptr_ctrl.sv
// Head/tail/count state for one circular queue: alloc at tail, free at head, squash rewinds tail.
// Count is registered; on squash it is recomputed from the new tail and the post-free head.
module lsq_ptr_ctrl
    import lsq_alloc_ctrl_pkg::*;
#(
    parameter int SIZE = 64,
    parameter int AW   = 3,
    parameter int FW   = 3,
    localparam int PW  = $clog2(SIZE) + 1,
    localparam int CW  = $clog2(SIZE + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] alloc_num_i,
    input  logic [FW-1:0] free_num_i,
    input  logic          squash_vld_i,
    input  logic [PW-1:0] squash_ptr_i,
    output logic [PW-1:0] head_o,
    output logic [PW-1:0] tail_o,
    output logic [CW-1:0] count_o
);

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        head_d = PW'(ptr_add(ptr_t'(head_q), ptr_t'(free_num_i), SIZE));
        if (squash_vld_i) begin
            tail_d  = squash_ptr_i;
            count_d = CW'(ptr_dist(ptr_t'(squash_ptr_i), ptr_t'(head_d), SIZE));
        end else begin
            tail_d  = PW'(ptr_add(ptr_t'(tail_q), ptr_t'(alloc_num_i), SIZE));
            count_d = count_q + CW'(alloc_num_i) - CW'(free_num_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign tail_o  = tail_q;
    assign count_o = count_q;

    a_free_le_count: assert property (@(posedge clk) disable iff (rst)
        CW'(free_num_i) <= count_q);

    a_squash_in_range: assert property (@(posedge clk) disable iff (rst)
        !squash_vld_i ||
        (ptr_dist(ptr_t'(squash_ptr_i), ptr_t'(head_q), SIZE) <=
         ptr_dist(ptr_t'(tail_q), ptr_t'(head_q), SIZE)));

endmodule

// File: rtl/lsq_alloc_ctrl.sv
// Dispatch-stage LQ/SQ allocator: in-order index assignment per group, whole-group stall on lack of space.
// Optional LSQ_ALLOC_FREE_BYPASS_EN lets this cycle's free count towards this cycle's space check.
module lsq_alloc_ctrl
    import lsq_alloc_ctrl_pkg::*;
#(
    parameter int DISP_WIDTH = 4,
    parameter int FREE_WIDTH = 4,
    parameter int LQ_SIZE    = LQSIZE,
    parameter int SQ_SIZE    = SQSIZE,
    localparam int FW  = $clog2(FREE_WIDTH + 1),
    localparam int AW  = $clog2(DISP_WIDTH + 1),
    localparam int LCW = $clog2(LQ_SIZE + 1),
    localparam int SCW = $clog2(SQ_SIZE + 1),
    localparam int LPW = $bits(lqIdx_t),
    localparam int SPW = $bits(sqIdx_t)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DISP_WIDTH-1:0]    i_disp_vld,
    input  logic [DISP_WIDTH-1:0]    i_disp_isld,
    input  logic [DISP_WIDTH-1:0]    i_disp_isst,
    output logic                     o_can_disp,
    output lqIdx_t [DISP_WIDTH-1:0]  o_lqIdx,
    output sqIdx_t [DISP_WIDTH-1:0]  o_sqIdx,
    input  logic [FW-1:0]            i_lq_free_num,
    input  logic [FW-1:0]            i_sq_free_num,
    input  logic                     i_squash_vld,
    input  lqIdx_t                   i_squash_lqIdx,
    input  sqIdx_t                   i_squash_sqIdx,
    output lqIdx_t                   o_lq_head,
    output sqIdx_t                   o_sq_head,
    output logic [LCW-1:0]           o_lq_count,
    output logic [SCW-1:0]           o_sq_count
);

    localparam int LSW = LCW + 1;
    localparam int SSW = SCW + 1;

    logic [AW-1:0]  nld, nst, lq_alloc, sq_alloc;
    logic [AW-1:0]  lq_pre [DISP_WIDTH];
    logic [AW-1:0]  sq_pre [DISP_WIDTH];
    logic [LPW-1:0] lq_tail;
    logic [SPW-1:0] sq_tail;
    logic [LSW-1:0] lq_space;
    logic [SSW-1:0] sq_space;
    logic           accept;

    // Exclusive prefix sums give each slot its offset from the current tail.
    always_comb begin
        nld = '0;
        nst = '0;
        for (int k = 0; k < DISP_WIDTH; k++) begin
            lq_pre[k] = nld;
            sq_pre[k] = nst;
            nld = nld + AW'(i_disp_vld[k] & i_disp_isld[k]);
            nst = nst + AW'(i_disp_vld[k] & i_disp_isst[k]);
        end
    end

    always_comb begin
        for (int k = 0; k < DISP_WIDTH; k++) begin
            o_lqIdx[k] = LPW'(ptr_add(ptr_t'(lq_tail), ptr_t'(lq_pre[k]), LQ_SIZE));
            o_sqIdx[k] = SPW'(ptr_add(ptr_t'(sq_tail), ptr_t'(sq_pre[k]), SQ_SIZE));
        end
    end

    always_comb begin
        lq_space = LSW'(LQ_SIZE) - LSW'(o_lq_count);
        sq_space = SSW'(SQ_SIZE) - SSW'(o_sq_count);
`ifdef LSQ_ALLOC_FREE_BYPASS_EN
        lq_space = lq_space + LSW'(i_lq_free_num);
        sq_space = sq_space + SSW'(i_sq_free_num);
`endif
        o_can_disp = !rst && !i_squash_vld &&
                     (lq_space >= LSW'(nld)) && (sq_space >= SSW'(nst));
    end

    assign accept   = o_can_disp && (|i_disp_vld);
    assign lq_alloc = accept ? nld : '0;
    assign sq_alloc = accept ? nst : '0;

    lsq_ptr_ctrl #(.SIZE(LQ_SIZE), .AW(AW), .FW(FW)) u_lq_ptr (
        .clk          (clk),
        .rst          (rst),
        .alloc_num_i  (lq_alloc),
        .free_num_i   (i_lq_free_num),
        .squash_vld_i (i_squash_vld),
        .squash_ptr_i (i_squash_lqIdx),
        .head_o       (o_lq_head),
        .tail_o       (lq_tail),
        .count_o      (o_lq_count)
    );

    lsq_ptr_ctrl #(.SIZE(SQ_SIZE), .AW(AW), .FW(FW)) u_sq_ptr (
        .clk          (clk),
        .rst          (rst),
        .alloc_num_i  (sq_alloc),
        .free_num_i   (i_sq_free_num),
        .squash_vld_i (i_squash_vld),
        .squash_ptr_i (i_squash_sqIdx),
        .head_o       (o_sq_head),
        .tail_o       (sq_tail),
        .count_o      (o_sq_count)
    );

endmodule
